audio_clk_gen: RTL and testbench



---
 rtl/audio_clk_pkg.sv | 35 +++
 rtl/nco_channel.sv | 41 ++++
 rtl/audio_clk_gen.sv | 95 +++++++++
 tb/tb_audio_clk_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_clk_pkg.sv
// Shared constants for the audio clock generator: accumulator width, mode
// encoding and the per-mode phase increments for a 50 MHz reference.
package audio_clk_pkg;

  localparam int unsigned ACC_W_DEF = 32;
  localparam int unsigned INC_W     = 32;
  localparam int unsigned MODE_W    = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_12M288  = 2'd0,
    MODE_11M2896 = 2'd1,
    MODE_24M576  = 2'd2,
    MODE_6M144   = 2'd3
  } mode_e;

  // round(f * 2^32 / 50e6)
  localparam logic [INC_W-1:0] INC_12M288  = 32'd1055531163;
  localparam logic [INC_W-1:0] INC_11M2896 = 32'd969769256;
  localparam logic [INC_W-1:0] INC_24M576  = 32'd2111062325;
  localparam logic [INC_W-1:0] INC_6M144   = 32'd527765581;

  function automatic logic [INC_W-1:0] mode_inc(input mode_e m);
    logic [INC_W-1:0] inc;
    inc = INC_12M288;
    case (m)
      MODE_12M288:  inc = INC_12M288;
      MODE_11M2896: inc = INC_11M2896;
      MODE_24M576:  inc = INC_24M576;
      MODE_6M144:   inc = INC_6M144;
      default:      inc = INC_12M288;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/nco_channel.sv
// One NCO output: phase accumulator with enable hold, MSB clock output and
// a registered strobe in the first cycle the output is high.
module nco_channel
  import audio_clk_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [ACC_W-1:0] i_inc,
  output logic             o_outclk,
  output logic             o_ce
);

  logic [ACC_W-1:0] r_acc;
  logic             r_ce;
  logic [ACC_W-1:0] w_acc_next;

  // Disabled channels sit at phase 0 so re-enable restarts cleanly
  always_comb begin
    w_acc_next = '0;
    if (i_en) begin
      w_acc_next = r_acc + i_inc;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_ce  <= 1'b0;
    end else begin
      r_acc <= w_acc_next;
      r_ce  <= w_acc_next[ACC_W-1] & ~r_acc[ACC_W-1];
    end
  end

  assign o_outclk = r_acc[ACC_W-1];
  assign o_ce     = r_ce;

endmodule

// File: rtl/audio_clk_gen.sv
// Multi-channel NCO audio clock generator: synchronises the mode select,
// tracks settling after mode changes and scales the increment per channel.
module audio_clk_gen
  import audio_clk_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned ACC_W      = ACC_W_DEF,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic [SEL_W-1:0]  i_freq_sel,
  input  logic [NUM_CH-1:0] i_ch_en,
  output logic [NUM_CH-1:0] o_outclk,
  output logic [NUM_CH-1:0] o_ce,
  output logic              o_locked
);

  localparam int unsigned CNT_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC);

  logic [SEL_W-1:0] r_sel_meta;
  logic [SEL_W-1:0] r_sel_s;
  logic [SEL_W-1:0] r_active_sel;
  logic [CNT_W-1:0] r_settle;
  logic             r_locked;

  logic [SEL_W-1:0] w_active_next;
  logic [CNT_W-1:0] w_settle_next;
  logic [INC_W-1:0] w_base_inc;
  logic [ACC_W-1:0] w_base_acc;

  // Two-flop synchroniser for the board-switch select
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_sel_meta <= '0;
      r_sel_s    <= '0;
    end else begin
      r_sel_meta <= i_freq_sel;
      r_sel_s    <= r_sel_meta;
    end
  end

  // Mode adoption and settle countdown; any new select restarts settling
  always_comb begin
    w_active_next = r_active_sel;
    w_settle_next = r_settle;
    if (r_sel_s != r_active_sel) begin
      w_active_next = r_sel_s;
      w_settle_next = SETTLE_LOAD;
    end else if (r_settle != '0) begin
      w_settle_next = r_settle - CNT_W'(1);
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_active_sel <= '0;
      r_settle     <= SETTLE_LOAD;
      r_locked     <= 1'b0;
    end else begin
      r_active_sel <= w_active_next;
      r_settle     <= w_settle_next;
      r_locked     <= (w_settle_next == '0);
    end
  end

  assign o_locked   = r_locked;
  assign w_base_inc = mode_inc(mode_e'(MODE_W'(r_active_sel)));

  // Table is in 2^32 units; rescale when the accumulator width differs
  if (ACC_W >= INC_W) begin : g_inc_up
    assign w_base_acc = ACC_W'(w_base_inc) << (ACC_W - INC_W);
  end else begin : g_inc_dn
    assign w_base_acc = ACC_W'(w_base_inc >> (INC_W - ACC_W));
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [ACC_W-1:0] w_ch_inc;
    assign w_ch_inc = w_base_acc >> c;

    nco_channel #(
      .ACC_W(ACC_W)
    ) u_nco (
      .refclk  (refclk),
      .rst     (rst),
      .i_en    (i_ch_en[c]),
      .i_inc   (w_ch_inc),
      .o_outclk(o_outclk[c]),
      .o_ce    (o_ce[c])
    );
  end

endmodule

// File: tb/tb_audio_clk_gen.sv
// Self-checking bench for audio_clk_gen: rate table, hand-written timing
// sequences and a randomized run against a frequency-level reference model.
module tb_audio_clk_gen;

  localparam int NUM_CH   = 2;
  localparam int SETTLE   = 16;
  localparam int WIN      = 6250;
  localparam int RAND_CYC = 3000;

  logic              refclk = 1'b0;
  logic              rst;
  logic [1:0]        freq_sel;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] outclk;
  logic [NUM_CH-1:0] ce;
  logic              locked;

  int total = 0;
  int bad   = 0;

  audio_clk_gen #(
    .NUM_CH    (NUM_CH),
    .ACC_W     (32),
    .SEL_W     (2),
    .SETTLE_CYC(SETTLE)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .i_freq_sel(freq_sel),
    .i_ch_en   (ch_en),
    .o_outclk  (outclk),
    .o_ce      (ce),
    .o_locked  (locked)
  );

  always #10 refclk = ~refclk;

  typedef struct {
    logic [1:0] sel;
    logic [1:0] en;
    int         exp10_0;  // expected rises in WIN cycles, x10
    int         exp10_1;
  } vec_t;

  vec_t tbl[5];

  int   hsel[0:RAND_CYC];

  // Nominal output frequency for a mode, from the board's audio rates
  function automatic longint freq_hz(input int mode);
    longint f;
    case (mode)
      0:       f = 12288000;
      1:       f = 11289600;
      2:       f = 24576000;
      default: f = 6144000;
    endcase
    return f;
  endfunction

  function automatic logic [31:0] bench_inc(input int mode, input int ch);
    longint unsigned num;
    logic [31:0]     base;
    num  = longint'(freq_hz(mode)) * 64'd4294967296 + 64'd25000000;
    base = 32'(num / 64'd50000000);
    return base >> ch;
  endfunction

  function automatic int hs(input int k);
    return (k < 1) ? 0 : hsel[k];
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic step();
    @(negedge refclk);
  endtask

  task automatic wait_locked(input string nm, input int maxc);
    int n;
    n = 0;
    while (!locked && n < maxc) begin
      step();
      n++;
    end
    chk(nm, longint'(locked), 1);
  endtask

  // Count rising edges and strobes per channel over n sampled cycles
  task automatic count_window(input int n, output int r0, output int r1,
                              output int c0, output int c1);
    logic [1:0] prev;
    prev = outclk;
    r0 = 0; r1 = 0; c0 = 0; c1 = 0;
    for (int i = 0; i < n; i++) begin
      step();
      r0 += int'(outclk[0] & ~prev[0]);
      r1 += int'(outclk[1] & ~prev[1]);
      c0 += int'(ce[0]);
      c1 += int'(ce[1]);
      prev = outclk;
    end
  endtask

  initial begin
    int         r0, r1, c0, c1, n, hi, k1, mode_t, last_chg;
    logic [31:0] ph[NUM_CH];
    logic [NUM_CH-1:0] m_out, m_ce;
    logic       m_lock, newo;

    // Rows: mode, enables, expected rises x10 for ch0/ch1 over WIN cycles
    tbl[0] = '{2'd0, 2'b11, 15360, 7680};
    tbl[1] = '{2'd1, 2'b11, 14112, 7056};
    tbl[2] = '{2'd2, 2'b11, 30720, 15360};
    tbl[3] = '{2'd3, 2'b11, 7680, 3840};
    tbl[4] = '{2'd2, 2'b01, 30720, 0};

    rst = 1'b1; freq_sel = 2'd0; ch_en = '0;
    step(); step();
    chk("reset_outclk", longint'(outclk), 0);
    chk("reset_ce", longint'(ce), 0);
    chk("reset_locked", longint'(locked), 0);

    // Power-up lock with unchanged select
    rst = 1'b0;
    n = 0;
    while (!locked && n < 40) begin
      step();
      n++;
    end
    chk_rng("powerup_lock_edges", n, SETTLE, SETTLE + 1);

    // Rate table
    for (int i = 0; i < 5; i++) begin
      ch_en = '0;
      freq_sel = tbl[i].sel;
      repeat (4) step();
      wait_locked("table_lock", 64);
      ch_en = tbl[i].en;
      count_window(WIN, r0, r1, c0, c1);
      chk_rng("table_rate_ch0", longint'(r0) * 10, tbl[i].exp10_0 - 10, tbl[i].exp10_0 + 10);
      chk_rng("table_rate_ch1", longint'(r1) * 10, tbl[i].exp10_1 - 10, tbl[i].exp10_1 + 10);
      chk("table_ce_ch0", c0, r0);
      chk("table_ce_ch1", c1, r1);
    end

    // Mode switch 0 -> 2: locked drops after N+2, returns after N+2+SETTLE
    ch_en = 2'b11;
    freq_sel = 2'd0;
    repeat (4) step();
    wait_locked("switch_prelock", 64);
    freq_sel = 2'd2;
    for (int k = 0; k <= SETTLE + 2; k++) begin
      step();
      chk("switch_locked", longint'(locked), (k < 2 || k >= SETTLE + 2) ? 1 : 0);
    end
    count_window(WIN, r0, r1, c0, c1);
    chk_rng("switch_rate_ch0", r0, 3071, 3073);
    chk_rng("switch_rate_ch1", r1, 1535, 1537);

    // Chattering select every 5 cycles
    hi = 0;
    for (int k = 0; k <= 45 + SETTLE + 2; k++) begin
      if (k % 5 == 0 && k <= 45) freq_sel = ((k / 5) % 2 == 0) ? 2'd0 : 2'd2;
      step();
      if (k >= 2 && k < 45 + SETTLE + 2 && locked) hi++;
      if (k == 45 + SETTLE + 2) chk("chatter_relock", longint'(locked), 1);
    end
    chk("chatter_locked_high_cycles", hi, 0);

    // Channel 1 disable / re-enable in mode 0
    freq_sel = 2'd0;
    repeat (4) step();
    wait_locked("disable_prelock", 64);
    ch_en = 2'b01;
    step();
    chk("disable_outclk1", longint'(outclk[1]), 0);
    chk("disable_ce1", longint'(ce[1]), 0);
    hi = 0;
    count_window(20, r0, r1, c0, c1);
    chk_rng("disable_ch0_running", r0, 4, 5);
    chk("disable_ch1_rises", r1, 0);
    k1 = int'((64'd2147483648 + 64'(bench_inc(0, 1)) - 64'd1) / 64'(bench_inc(0, 1)));
    ch_en = 2'b11;
    n = 0;
    do begin
      step();
      n++;
    end while (!outclk[1] && n < 100);
    chk("reenable_first_rise", n, k1);
    chk("reenable_ce1", longint'(ce[1]), 1);

    // Asynchronous reset while outclk[0] is high
    n = 0;
    while (!outclk[0] && n < 20) begin
      step();
      n++;
    end
    chk("midreset_outclk_high", longint'(outclk[0]), 1);
    #3 rst = 1'b1;
    #1;
    chk("midreset_outclk", longint'(outclk), 0);
    chk("midreset_ce", longint'(ce), 0);
    chk("midreset_locked", longint'(locked), 0);
    step();
    freq_sel = 2'd3; ch_en = '0; rst = 1'b0;
    n = 0;
    while (!locked && n < 60) begin
      step();
      n++;
    end
    chk("midreset_relock_edges", n, SETTLE + 3);

    // Randomized run against the reference model, starting from reset
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    freq_sel = 2'($urandom_range(0, 3));
    ch_en = 2'b11;
    for (int c = 0; c < NUM_CH; c++) ph[c] = '0;
    m_out = '0; m_ce = '0; last_chg = 0;
    for (int t = 1; t <= RAND_CYC; t++) begin
      if (t > 1) begin
        if ($urandom_range(0, 79) == 0) freq_sel = 2'($urandom_range(0, 3));
        for (int c = 0; c < NUM_CH; c++)
          if ($urandom_range(0, 29) == 0) ch_en[c] = ~ch_en[c];
      end
      hsel[t] = int'(freq_sel);
      @(posedge refclk);
      mode_t = hs(t - 3);
      if (hs(t - 2) != hs(t - 3)) last_chg = t;
      for (int c = 0; c < NUM_CH; c++) begin
        ph[c] = ch_en[c] ? ph[c] + bench_inc(mode_t, c) : 32'd0;
        newo = ph[c][31];
        m_ce[c]  = newo & ~m_out[c];
        m_out[c] = newo;
      end
      m_lock = (t - last_chg >= SETTLE);
      @(negedge refclk);
      chk("rand_outclk", longint'(outclk), longint'(m_out));
      chk("rand_ce", longint'(ce), longint'(m_ce));
      chk("rand_locked", longint'(locked), longint'(m_lock));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
